// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX-stage to multiply/divide unit handshake and HI/LO result bus.
interface mdu_ctrl_if;
  logic        ex_valid;
  logic [2:0]  ex_mdop;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        exc_oc;
  logic        mdu_stall;
  logic        mdu_busy;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output ex_valid, ex_mdop, ex_a, ex_b, exc_oc, input mdu_stall, mdu_busy, hi, lo);
  modport slave (input ex_valid, ex_mdop, ex_a, ex_b, exc_oc, output mdu_stall, mdu_busy, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MULT/DIV sequencer owning HI/LO, stalling EX while busy.
module mdu_ctrl #(
  parameter int MUL_LAT = 2
) (
  input logic clk,
  input logic resetn,
  mdu_ctrl_if.slave m
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [4:0] cnt, cnt_n;
  logic [31:0] ma, mb, quo, rem;
  logic sa, sb;
  logic is_mul, is_div, is_sgn, start, a_neg, b_neg, fin, mt;
  logic [31:0] a_mag, b_mag, quo_n, rem_n, sub, q_fix, r_fix;
  logic [32:0] r_sh;
  logic ge;
  logic [63:0] pa, pb, prod;
  always_comb begin
    is_mul = m.ex_mdop == 3'd1 || m.ex_mdop == 3'd2;
    is_div = m.ex_mdop == 3'd3 || m.ex_mdop == 3'd4;
    is_sgn = m.ex_mdop == 3'd1 || m.ex_mdop == 3'd3;
    start  = m.ex_valid && (is_mul || is_div) && !m.exc_oc && state == IDLE;
    mt     = m.ex_valid && !m.exc_oc && state == IDLE;
    a_neg  = is_sgn && m.ex_a[31];
    b_neg  = is_sgn && m.ex_b[31];
    a_mag  = a_neg ? -m.ex_a : m.ex_a;
    b_mag  = b_neg ? -m.ex_b : m.ex_b;
    fin    = !m.exc_oc && cnt == 5'd0;
    pa     = sa ? -{32'b0, ma} : {32'b0, ma};
    pb     = sb ? -{32'b0, mb} : {32'b0, mb};
    prod   = pa * pb;
    // restoring step: shift in the next dividend bit, subtract divisor if it fits
    r_sh   = {rem, quo[31]};
    ge     = r_sh >= {1'b0, mb};
    sub    = r_sh[31:0] - mb;
    rem_n  = ge ? sub : r_sh[31:0];
    quo_n  = {quo[30:0], ge};
    q_fix  = (sa ^ sb) ? -quo_n : quo_n;
    r_fix  = sa ? -rem_n : rem_n;
    m.mdu_stall = resetn && !m.exc_oc && (start || state == MUL || state == DIV);
    m.mdu_busy  = state != IDLE;
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (start) begin
        state_n = is_mul ? MUL : DIV;
        cnt_n   = is_mul ? 5'(MUL_LAT - 1) : 5'd31;
      end
      MUL, DIV: if (cnt == 5'd0) state_n = DONE; else cnt_n = cnt - 5'd1;
      default: state_n = IDLE;
    endcase
    if (m.exc_oc) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      m.hi  <= '0;
      m.lo  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (start) begin
        ma  <= a_mag;
        mb  <= b_mag;
        sa  <= a_neg;
        sb  <= b_neg;
        quo <= a_mag;
        rem <= '0;
      end
      if (state == DIV && !m.exc_oc) begin
        quo <= quo_n;
        rem <= rem_n;
      end
      if (state == MUL && fin) begin
        m.hi <= prod[63:32];
        m.lo <= prod[31:0];
      end
      if (state == DIV && fin) begin
        m.hi <= r_fix;
        m.lo <= q_fix;
      end
      if (mt && m.ex_mdop == 3'd5) m.hi <= m.ex_a;
      if (mt && m.ex_mdop == 3'd6) m.lo <= m.ex_a;
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized and directed checks of mdu_ctrl against an arithmetic model.
module tb_mdu_ctrl;
  localparam int LAT = 2;
  logic clk = 0;
  logic resetn = 0;
  int checks = 0;
  int errors = 0;
  mdu_ctrl_if bus();
  mdu_ctrl #(.MUL_LAT(LAT)) dut (.clk(clk), .resetn(resetn), .m(bus));
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    logic signed [63:0] sa, sb, p, q, r;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    eh = 'x;
    el = 'x;
    case (op)
      3'd1: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      3'd2: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
      3'd3: if (b == 0) begin eh = a; el = a[31] ? 32'd1 : 32'hFFFFFFFF; end
            else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      3'd4: if (b == 0) begin eh = a; el = 32'hFFFFFFFF; end
            else begin el = a / b; eh = a % b; end
      default: ;
    endcase
  endfunction
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output logic [31:0] oh, output logic [31:0] ol, output logic ob);
    @(negedge clk);
    bus.ex_valid = 1;
    bus.ex_mdop = op;
    bus.ex_a = a;
    bus.ex_b = b;
    stalls = 0;
    #1;
    for (int i = 0; i < 100 && bus.mdu_stall; i++) begin
      stalls++;
      @(negedge clk);
      bus.ex_a = $urandom;
      bus.ex_b = $urandom;
      #1;
    end
    oh = bus.hi;
    ol = bus.lo;
    ob = bus.mdu_busy;
  endtask
  task automatic idle();
    @(negedge clk);
    bus.ex_valid = 0;
    bus.ex_mdop = 0;
    #1;
  endtask
  task automatic test_reset();
    resetn = 0;
    bus.exc_oc = 0;
    bus.ex_valid = 1;
    bus.ex_mdop = 3'd3;
    bus.ex_a = 32'd50;
    bus.ex_b = 32'd5;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.mdu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.mdu_stall); end
    checks++; if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.mdu_busy); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
    bus.ex_valid = 0;
    bus.ex_mdop = 0;
    @(negedge clk);
    resetn = 1;
  endtask
  task automatic test_mult();
    int s; logic [31:0] h, l; logic b;
    issue(3'd1, 32'hFFFFFFFB, 32'd3, s, h, l, b);
    checks++; if (s !== 1 + LAT) begin errors++; $display("FAIL mult_stalls got %0d exp %0d", s, 1 + LAT); end
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", h); end
    checks++; if (l !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo got %h exp fffffff1", l); end
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL mult_done_busy got %b exp 1", b); end
    idle();
    checks++; if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL mult_after_busy got %b exp 0", bus.mdu_busy); end
  endtask
  task automatic test_divu();
    int s; logic [31:0] h, l; logic b;
    issue(3'd4, 32'd100, 32'd7, s, h, l, b);
    checks++; if (s !== 33) begin errors++; $display("FAIL divu_stalls got %0d exp 33", s); end
    checks++; if (l !== 32'd14) begin errors++; $display("FAIL divu_lo got %h exp 0000000e", l); end
    checks++; if (h !== 32'd2) begin errors++; $display("FAIL divu_hi got %h exp 00000002", h); end
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL divu_done_busy got %b exp 1", b); end
    idle();
    checks++; if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL divu_after_busy got %b exp 0", bus.mdu_busy); end
  endtask
  task automatic test_div_signed();
    int s; logic [31:0] h, l; logic b;
    issue(3'd3, 32'hFFFFFFF9, 32'd2, s, h, l, b);
    checks++; if (l !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo got %h exp fffffffd", l); end
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi got %h exp ffffffff", h); end
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, s, h, l, b);
    checks++; if (l !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", l); end
    checks++; if (h !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h exp 0", h); end
    checks++; if (s !== 33) begin errors++; $display("FAIL div_ovf_stalls got %0d exp 33", s); end
  endtask
  task automatic test_div_zero_mthi();
    int s; logic [31:0] h, l; logic b;
    issue(3'd4, 32'h1234, 32'd0, s, h, l, b);
    checks++; if (l !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_lo got %h exp ffffffff", l); end
    checks++; if (h !== 32'h1234) begin errors++; $display("FAIL divz_hi got %h exp 00001234", h); end
    issue(3'd5, 32'hCAFEBABE, 32'd0, s, h, l, b);
    checks++; if (s !== 0) begin errors++; $display("FAIL mthi_stalls got %0d exp 0", s); end
    idle();
    checks++; if (bus.hi !== 32'hCAFEBABE) begin errors++; $display("FAIL mthi_hi got %h exp cafebabe", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL mthi_lo_kept got %h exp ffffffff", bus.lo); end
  endtask
  task automatic test_flush();
    int s; logic [31:0] h, l, eh, el; logic b;
    issue(3'd5, 32'h11111111, 32'd0, s, h, l, b);
    issue(3'd6, 32'h11111111, 32'd0, s, h, l, b);
    @(negedge clk);
    bus.ex_mdop = 3'd3;
    bus.ex_a = 32'd1000;
    bus.ex_b = 32'd3;
    repeat (11) @(negedge clk);
    bus.exc_oc = 1;
    #1;
    checks++; if (bus.mdu_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", bus.mdu_stall); end
    @(negedge clk);
    bus.exc_oc = 0;
    bus.ex_valid = 0;
    bus.ex_mdop = 0;
    #1;
    checks++; if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", bus.mdu_busy); end
    checks++; if (bus.hi !== 32'h11111111) begin errors++; $display("FAIL flush_hi got %h exp 11111111", bus.hi); end
    checks++; if (bus.lo !== 32'h11111111) begin errors++; $display("FAIL flush_lo got %h exp 11111111", bus.lo); end
    model(3'd4, 32'd12345, 32'd17, eh, el);
    issue(3'd4, 32'd12345, 32'd17, s, h, l, b);
    checks++; if (s !== 33) begin errors++; $display("FAIL flush_redo_stalls got %0d exp 33", s); end
    checks++; if (l !== el) begin errors++; $display("FAIL flush_redo_lo got %h exp %h", l, el); end
    checks++; if (h !== eh) begin errors++; $display("FAIL flush_redo_hi got %h exp %h", h, eh); end
  endtask
  task automatic test_reset_mid();
    int s; logic [31:0] h, l; logic b;
    @(negedge clk);
    bus.ex_valid = 1;
    bus.ex_mdop = 3'd4;
    bus.ex_a = 32'd777;
    bus.ex_b = 32'd5;
    repeat (21) @(negedge clk);
    resetn = 0;
    #1;
    checks++; if (bus.mdu_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b exp 0", bus.mdu_stall); end
    @(negedge clk);
    resetn = 1;
    bus.ex_valid = 0;
    bus.ex_mdop = 0;
    #1;
    checks++; if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.mdu_busy); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL rstmid_hilo got %h/%h exp 0/0", bus.hi, bus.lo); end
    issue(3'd2, 32'hFFFFFFFF, 32'd2, s, h, l, b);
    checks++; if (h !== 32'h1 || l !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_multu got %h/%h exp 00000001/fffffffe", h, l); end
    issue(3'd4, 32'd9, 32'd3, s, h, l, b);
    checks++; if (l !== 32'd3 || h !== 32'd0) begin errors++; $display("FAIL b2b_divu got lo %h hi %h exp 3/0", l, h); end
    checks++; if (s !== 33) begin errors++; $display("FAIL b2b_divu_stalls got %0d exp 33", s); end
  endtask
  task automatic test_random();
    int s, es; logic [31:0] a, bb, h, l, eh, el; logic b; logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 4));
      a = $urandom;
      bb = $urandom;
      case ($urandom_range(0, 5))
        0: bb = 32'($urandom_range(0, 9));
        1: a = 32'h80000000;
        2: bb = 32'hFFFFFFFF;
        3: bb = 32'd0;
        default: ;
      endcase
      model(op, a, bb, eh, el);
      es = (op <= 3'd2) ? 1 + LAT : 33;
      issue(op, a, bb, s, h, l, b);
      checks++; if (s !== es) begin errors++; $display("FAIL rand_stalls op %0d got %0d exp %0d", op, s, es); end
      checks++; if (h !== eh) begin errors++; $display("FAIL rand_hi op %0d a %h b %h got %h exp %h", op, a, bb, h, eh); end
      checks++; if (l !== el) begin errors++; $display("FAIL rand_lo op %0d a %h b %h got %h exp %h", op, a, bb, l, el); end
    end
    idle();
  endtask
  initial begin
    bus.ex_valid = 0;
    bus.ex_mdop = 0;
    bus.ex_a = 0;
    bus.ex_b = 0;
    bus.exc_oc = 0;
    test_reset();
    test_mult();
    test_divu();
    test_div_signed();
    test_div_zero_mthi();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
